// File: rtl/apple2_bus_host.sv
// apple2_bus_host: Apple II slot-bus initiator generating PHI1/PHI0, address, data and slot
// strobes from a valid/ready request port, one 6502-style bus cycle per accepted request.
module apple2_bus_host #(
   parameter int SLOT    = 6,
   parameter int LONGCYC = 65
) (
   input  logic        i_c7m,
   input  logic        i_res,
   output logic        o_nres,
   output logic        o_phi1,
   output logic        o_phi0,
   output logic [15:0] o_a,
   output logic        o_nwe,
   output logic [7:0]  o_dout,
   output logic        o_doe,
   input  logic [7:0]  i_din,
   output logic        o_ndevsel,
   output logic        o_niosel,
   output logic        o_niostrb,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_wr,
   input  logic [15:0] i_req_addr,
   input  logic [7:0]  i_req_wdata,
   output logic        o_rsp_valid,
   output logic [7:0]  o_rsp_rdata
);
   localparam logic [6:0] LC_LAST = 7'(LONGCYC - 1);
   localparam logic [3:0] DEV_NIB = 4'(8 + SLOT);
   localparam logic [7:0] IO_PAGE = 8'(192 + SLOT);

   logic [2:0]  r_ph;
   logic [6:0]  r_cc;
   logic        r_act;
   logic        r_nres;
   logic        r_phi1;
   logic        r_phi0;
   logic [15:0] r_a;
   logic        r_nwe;
   logic [7:0]  r_dout;
   logic        r_doe;
   logic        r_ndev;
   logic        r_nio;
   logic        r_nstrb;
   logic        r_rsp;
   logic [7:0]  r_rdata;

   logic        w_long;
   logic        w_wrap;
   logic [6:0]  w_cc_n;
   logic        w_dev;
   logic        w_io;
   logic        w_strb;

   assign w_long = (LONGCYC != 0) && (r_cc == LC_LAST);
   assign w_wrap = r_ph == (w_long ? 3'd7 : 3'd6);
   assign w_cc_n = (LONGCYC == 0 || r_cc == LC_LAST) ? 7'd0 : r_cc + 7'd1;
   assign w_dev  = r_a[15:8] == 8'hC0 && r_a[7:4] == DEV_NIB;
   assign w_io   = r_a[15:8] == IO_PAGE;
   assign w_strb = r_a[15:11] == 5'b11001;

   assign o_req_ready = w_wrap & ~i_res;
   assign o_nres      = r_nres;
   assign o_phi1      = r_phi1;
   assign o_phi0      = r_phi0;
   assign o_a         = r_a;
   assign o_nwe       = r_nwe;
   assign o_dout      = r_dout;
   assign o_doe       = r_doe;
   assign o_ndevsel   = r_ndev;
   assign o_niosel    = r_nio;
   assign o_niostrb   = r_nstrb;
   assign o_rsp_valid = r_rsp;
   assign o_rsp_rdata = r_rdata;

   always_ff @(posedge i_c7m) begin
      if (i_res) begin
         r_ph    <= 3'd0;
         r_cc    <= 7'd0;
         r_act   <= 1'b0;
         r_nres  <= 1'b0;
         r_phi1  <= 1'b1;
         r_phi0  <= 1'b0;
         r_a     <= 16'h0000;
         r_nwe   <= 1'b1;
         r_dout  <= 8'h00;
         r_doe   <= 1'b0;
         r_ndev  <= 1'b1;
         r_nio   <= 1'b1;
         r_nstrb <= 1'b1;
         r_rsp   <= 1'b0;
         r_rdata <= 8'h00;
      end else begin
         r_nres <= 1'b1;
         if (w_wrap) begin
            // this edge ends one cycle and starts the next: capture, complete and accept together
            r_ph    <= 3'd0;
            r_cc    <= w_cc_n;
            r_phi1  <= 1'b1;
            r_phi0  <= 1'b0;
            r_doe   <= 1'b0;
            r_ndev  <= 1'b1;
            r_nio   <= 1'b1;
            r_nstrb <= 1'b1;
            r_rsp   <= r_act;
            r_act   <= i_req_valid;
            r_nwe   <= ~(i_req_valid & i_req_wr);
            if (r_act & r_nwe)
               r_rdata <= i_din;
            if (i_req_valid)
               r_a <= i_req_addr;
            if (i_req_valid & i_req_wr)
               r_dout <= i_req_wdata;
         end else begin
            r_ph  <= r_ph + 3'd1;
            r_rsp <= 1'b0;
            if (r_ph == 3'd3) begin
               r_phi1  <= 1'b0;
               r_phi0  <= 1'b1;
               r_doe   <= r_act & ~r_nwe;
               r_ndev  <= ~(r_act & w_dev);
               r_nio   <= ~(r_act & w_io);
               r_nstrb <= ~(r_act & w_strb);
            end
         end
      end
   end
endmodule

// File: tb/tb_apple2_bus_host.sv
// tb_apple2_bus_host: directed and randomized bus transactions checked every C7M against
// a cycle-level model of the slot bus, plus literal timing expectations.
module tb_apple2_bus_host;
   localparam int SLOT = 6;
   localparam int LC   = 4;

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic [7:0]  din = 8'h00;
   logic        req_valid = 1'b0;
   logic        req_wr = 1'b0;
   logic [15:0] req_addr = 16'h0000;
   logic [7:0]  req_wdata = 8'h00;
   logic        nres, phi1, phi0, nwe, doe, ndevsel, niosel, niostrb, req_ready, rsp_valid;
   logic [15:0] a;
   logic [7:0]  dout, rsp_rdata;

   int total = 0;
   int bad = 0;
   int ncnt = 0;
   int rsp_cnt = 0, rsp_last = 0, rsp_prev = 0;
   bit din_force = 1'b0;
   logic [7:0] din_val = 8'h00;

   always #5 clk = ~clk;

   apple2_bus_host #(.SLOT(SLOT), .LONGCYC(LC)) dut (
      .i_c7m(clk), .i_res(res), .o_nres(nres), .o_phi1(phi1), .o_phi0(phi0), .o_a(a),
      .o_nwe(nwe), .o_dout(dout), .o_doe(doe), .i_din(din), .o_ndevsel(ndevsel),
      .o_niosel(niosel), .o_niostrb(niostrb), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata)
   );

   // cycle-level model: m_cyc counts whole bus cycles since reset, m_ph the C7M within it
   bit          m_on = 1'b0, m_act, m_wr, m_nres, m_rsp;
   int          m_ph, m_cyc;
   logic [15:0] m_a;
   logic [7:0]  m_wdata, m_rdata;

   function automatic int mlen(input int c);
      return (LC != 0 && c % LC == LC - 1) ? 8 : 7;
   endfunction

   always @(posedge clk) begin
      ncnt++;
      if (res) begin
         m_on = 1'b1; m_ph = 0; m_cyc = 0; m_act = 0; m_wr = 0; m_a = 0;
         m_wdata = 0; m_rdata = 0; m_rsp = 0; m_nres = 0;
      end else if (m_on) begin
         m_nres = 1'b1;
         if (m_ph == mlen(m_cyc) - 1) begin
            m_rsp = m_act;
            if (m_act && !m_wr) m_rdata = din;
            m_act = req_valid;
            if (req_valid) begin
               m_a = req_addr;
               m_wr = req_wr;
               if (req_wr) m_wdata = req_wdata;
            end
            m_ph = 0;
            m_cyc++;
         end else begin
            m_ph++;
            m_rsp = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      #1;
      din = din_force ? din_val : 8'($urandom);
   end

   function automatic logic [41:0] expv();
      int  ad = int'(m_a);
      bit  on = m_act && m_ph >= 4;
      bit  dv = on && ad >= 'hC080 + 16 * SLOT && ad < 'hC090 + 16 * SLOT;
      bit  io = on && (ad >> 8) == 'hC0 + SLOT;
      bit  st = on && ad >= 'hC800 && ad <= 'hCFFF;
      bit  oe = m_act && m_wr && m_ph >= 4;
      bit  rd = (m_ph == mlen(m_cyc) - 1) && !res;
      bit  p1 = m_ph < 4;
      bit  we = !(m_act && m_wr);
      return {m_nres, p1, !p1, m_a, we, oe, oe ? m_wdata : 8'h00, !dv, !io, !st, rd, m_rsp, m_rdata};
   endfunction

   task automatic cmp_loop();
      logic [41:0] e, g;
      forever begin
         @(negedge clk);
         if (m_on) begin
            e = expv();
            g = {nres, phi1, phi0, a, nwe, doe, e[21] ? dout : 8'h00, ndevsel, niosel, niostrb,
                 req_ready, rsp_valid, rsp_rdata};
            total++;
            if (g !== e) begin
               bad++;
               if (bad < 30) $display("FAIL bus_state at edge %0d: got=%h want=%h", ncnt, g, e);
            end
            if (rsp_valid) begin
               rsp_prev = rsp_last;
               rsp_last = ncnt;
               rsp_cnt++;
            end
         end
      end
   endtask

   task automatic chk(input string n, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", n, got, want);
      end
   endtask

   task automatic wait_for(input int sel, input bit v, output int t);
      t = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((sel == 0 ? phi1 : req_ready) == v) begin
            t = ncnt;
            break;
         end
      end
      if (t < 0) begin
         total++;
         bad++;
         $display("FAIL wait_timeout sel=%0d: got=none want=%0d", sel, v);
         t = 0;
      end
   endtask

   task automatic sync(input int r);
      bit ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = m_ph == 0 && m_cyc % LC == r;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL sync_timeout: got=none want=%0d", r);
      end
   endtask

   task automatic issue(input int r, input bit w, input logic [15:0] ad, input logic [7:0] d,
                        input bit hold, output int t);
      sync(r);
      #1;
      req_valid = 1'b1; req_wr = w; req_addr = ad; req_wdata = d;
      wait_for(1, 1'b1, t);
      if (!hold) begin
         @(negedge clk);
         #1;
         req_valid = 1'b0;
         req_wr = 1'($urandom);
         req_addr = 16'($urandom);
         req_wdata = 8'($urandom);
      end
   endtask

   task automatic directed();
      int t0, t, t1, t2, tp1, tr1, n, sel;
      repeat (3) @(negedge clk);
      chk("rst_nres", nres, 0);
      chk("rst_phi", {phi1, phi0}, 2'b10);
      chk("rst_a", a, 0);
      chk("rst_ctl", {nwe, doe, dout}, 10'h200);
      chk("rst_strobes", {ndevsel, niosel, niostrb}, 3'b111);
      chk("rst_hs", {req_ready, rsp_valid, rsp_rdata}, 0);
      #1 res = 1'b0;
      t0 = ncnt;
      wait_for(0, 1'b0, t);  chk("phi1_fall", t - t0, 4);
      wait_for(1, 1'b1, tr1); chk("ready_first", tr1 - t0, 6);
      wait_for(0, 1'b1, tp1); chk("first_cycle_len", tp1 - t0, 7);
      wait_for(1, 1'b1, t);  chk("ready_period", t - tr1, 7);
      wait_for(0, 1'b1, t);  chk("phi1_period", t - tp1, 7);

      issue(0, 1'b1, 16'hC0E0, 8'h5A, 1'b0, t);
      chk("wr_ph0_nwe_a", {nwe, a}, {1'b0, 16'hC0E0});
      chk("wr_ph0_doe", doe, 0);
      repeat (5) @(negedge clk);
      chk("wr_ph5_dev_doe", {ndevsel, doe}, 2'b01);
      chk("wr_ph5_dout", dout, 8'h5A);
      chk("wr_ph5_io_strb", {niosel, niostrb}, 2'b11);
      n = rsp_cnt;
      repeat (3) @(negedge clk);
      chk("wr_rsp_count", rsp_cnt - n, 1);
      chk("wr_rsp_latency", rsp_last - t, 8);

      issue(1, 1'b0, 16'hC600, 8'h00, 1'b0, t);
      repeat (5) @(negedge clk);
      chk("rd_ph5_io_doe_nwe", {niosel, doe, nwe}, 3'b001);
      @(negedge clk);
      din_val = 8'hA9;
      din_force = 1'b1;
      @(negedge clk);
      chk("rd_rsp", rsp_valid, 1);
      chk("rd_data", rsp_rdata, 8'hA9);
      chk("rd_latency", ncnt - t, 8);
      din_force = 1'b0;

      issue(0, 1'b0, 16'hC800, 8'h00, 1'b1, t1);
      @(negedge clk);
      #1 req_addr = 16'hCFFF;
      chk("b2b_a1", a, 16'hC800);
      repeat (5) @(negedge clk);
      chk("b2b_strb1", niostrb, 0);
      wait_for(1, 1'b1, t2);
      chk("b2b_accept_gap", t2 - t1, 7);
      @(negedge clk);
      #1 req_valid = 1'b0;
      chk("b2b_a2", a, 16'hCFFF);
      repeat (5) @(negedge clk);
      chk("b2b_strb2", niostrb, 0);
      repeat (3) @(negedge clk);
      chk("b2b_rsp_gap", rsp_last - rsp_prev, 7);

      issue(2, 1'b0, 16'hC0E5, 8'h00, 1'b0, t);
      repeat (6) @(negedge clk);
      din_val = 8'h11;
      din_force = 1'b1;
      chk("lg_ph6_dev", ndevsel, 0);
      @(negedge clk);
      din_val = 8'h3C;
      chk("lg_ph7_phi0_dev_rdy", {phi0, ndevsel, req_ready}, 3'b101);
      @(negedge clk);
      chk("lg_rsp_data", {rsp_valid, rsp_rdata}, {1'b1, 8'h3C});
      chk("lg_latency", ncnt - t, 9);
      din_force = 1'b0;

      issue(0, 1'b1, 16'hC0E3, 8'h77, 1'b0, t);
      repeat (5) @(negedge clk);
      chk("rm_pre_dev_doe", {ndevsel, doe}, 2'b01);
      n = rsp_cnt;
      #1 res = 1'b1;
      @(negedge clk);
      chk("rm_dev_doe", {ndevsel, doe}, 2'b10);
      @(negedge clk);
      #1 res = 1'b0;
      repeat (16) @(negedge clk);
      chk("rm_no_rsp", rsp_cnt - n, 0);

      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         #1;
         sel = $urandom_range(0, 4);
         req_valid = $urandom_range(0, 9) < 7;
         req_wr = 1'($urandom);
         req_wdata = 8'($urandom);
         req_addr = sel == 0 ? 16'hC080 + 16'($urandom_range(0, 127)) :
                    sel == 1 ? {8'hC0 + 8'($urandom_range(0, 7)), 8'($urandom)} :
                    sel == 2 ? 16'hC800 + 16'($urandom_range(0, 2047)) :
                    sel == 3 ? ($urandom_range(0, 1) ? 16'hC7FF : 16'hD000) : 16'($urandom);
         res = $urandom_range(0, 299) == 0;
      end
      #1;
      res = 1'b0;
      req_valid = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      fork
         cmp_loop();
         directed();
      join_any
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
